pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of period/duty counters.
REQ-002 SHALL have parameter DT_W, default 8: width of dead-time counter.
REQ-003 SHALL have port clk  input  1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1: run request.
REQ-006 SHALL have port load  input  1: single-cycle strobe capturing period/duty/deadtime into shadow registers.
REQ-007 SHALL have port period  input  CNT_W: switching period in clk cycles.
REQ-008 SHALL have port duty  input  CNT_W: on-time of raw PWM in clk cycles.
REQ-009 SHALL have port deadtime  input  DT_W: dead-time in clk cycles.
REQ-010 SHALL have port ctrl  output  1: high-side gate drive (feeds filter ctrl input).
REQ-011 SHALL have port ctrl_n  output  1: low-side complementary gate drive.
REQ-012 SHALL have port cycle_start  output  1: one-cycle pulse at counter wrap to 0.
REQ-013 SHALL have port load_err  output  1: one-cycle pulse on rejected load.

Function
REQ-014 SHALL hold shadow (period_s, duty_s, dt_s) and active (period_a, duty_a, dt_a) register sets.
REQ-015 SHALL accept load only if period >= 2; accepted values enter shadow on the load edge.
REQ-016 SHALL, on load with period < 2, leave shadow unchanged and pulse load_err the next cycle.
REQ-017 SHALL copy shadow to active only on entry to RUN and on each wrap (cnt == period_a-1); never mid-period.
REQ-018 SHALL, for load coinciding with a wrap edge, capture into shadow only; new values apply at the following wrap.
REQ-019 SHALL implement FSM states IDLE, RUN, STOP.
REQ-020 IDLE: cnt = 0, ctrl = ctrl_n = 0; en=1 -> RUN, load active from shadow, cnt = 0.
REQ-021 RUN: cnt increments, wraps period_a-1 -> 0 with cycle_start pulse; en=0 -> STOP.
REQ-022 STOP: continue counting until wrap, then -> IDLE (no truncated period); en=1 in STOP -> RUN without restart.
REQ-023 SHALL pulse cycle_start on the first RUN cycle (cnt = 0) and each subsequent cnt = 0 in RUN.
REQ-024 SHALL form raw = (cnt < duty_a) in RUN/STOP, 0 in IDLE; duty_a >= period_a gives raw constantly 1.
REQ-025 SHALL register outputs: ctrl/ctrl_n reflect raw of the previous cycle plus dead-time (1-cycle latency).
REQ-026 SHALL assert ctrl only after raw has been 1 for dt_a consecutive cycles; deassert on raw falling, same latency.
REQ-027 SHALL assert ctrl_n only after raw has been 0 for dt_a consecutive cycles; deassert on raw rising, same latency.
REQ-028 SHALL never drive ctrl and ctrl_n high in the same cycle, for any inputs.
REQ-029 dt_a = 0: ctrl = raw delayed 1, ctrl_n = !raw delayed 1 in RUN/STOP.
REQ-030 SHALL suppress a pulse entirely when its width <= dt_a (both outputs low).
REQ-031 SHALL use unsigned compare only; no arithmetic overflow paths (cnt never exceeds period_a-1).

Reset
REQ-032 rst=1 SHALL asynchronously force: state IDLE, cnt 0, dead-time counter 0, ctrl 0, ctrl_n 0, cycle_start 0, load_err 0.
REQ-033 rst SHALL set shadow and active to period = 2^CNT_W-1, duty = 0, deadtime = 0 (output off).
REQ-034 rst asserted mid-period SHALL drop both outputs low immediately, without waiting for clk.
REQ-035 Release of rst SHALL take effect on the first clk edge after deassertion; no output glitch on release.

Verification
REQ-036 load period=10 duty=5 dt=0, en=1 -> ctrl 5 high/5 low repeating, cycle_start every 10 cycles, first ctrl high 1 cycle after RUN entry.
REQ-037 period=10 duty=5 dt=2 -> ctrl high 3 cycles, ctrl_n high 3 cycles, both low 2 cycles at each edge, never overlapping.
REQ-038 Mid-period load duty=8 -> current period unchanged, duty 8 from next cycle_start; load coincident with wrap -> applies one period later.
REQ-039 load period=1 -> load_err pulse 1 cycle, waveform unchanged; duty=0 -> ctrl always 0; duty=12 with period=10 -> ctrl always 1.
REQ-040 en dropped at cnt=3 -> period completes to cnt=9, then IDLE with outputs 0; rst at cnt=4 -> outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/pwm_gen.sv
// Complementary PWM generator: shadowed period/duty/dead-time that take effect per period,
// registered gate drives with dead-time insertion, and graceful stop at the end of a period.
module pwm_gen #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic [DT_W-1:0]  deadtime,
    output logic             ctrl,
    output logic             ctrl_n,
    output logic             cycle_start,
    output logic             load_err
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    localparam logic [CNT_W-1:0] PeriodRst = '1;
    localparam logic [CNT_W-1:0] PeriodMin = CNT_W'(2);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [DT_W-1:0]  RunMax    = '1;
    localparam logic [DT_W-1:0]  RunOne    = DT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] period_s_q, duty_s_q;
    logic [DT_W-1:0]  dt_s_q;
    logic [CNT_W-1:0] period_a_q, duty_a_q;
    logic [DT_W-1:0]  dt_a_q;

    // Length (minus one) of the current run of equal raw values, saturating.
    logic [DT_W-1:0]  run_q, run_d;
    logic             raw_q;
    logic             valid_q;

    logic             ctrl_q, ctrl_d;
    logic             ctrl_n_q, ctrl_n_d;
    logic             cycle_start_q, cycle_start_d;
    logic             load_err_q, load_err_d;

    logic             raw;
    logic             wrap;
    logic             load_ok;
    logic             reload;
    logic             same;
    logic             settled;
    logic             live;

    always_comb begin
        raw     = (state_q != StIdle) && (cnt_q < duty_a_q);
        wrap    = (cnt_q == period_a_q - CntOne);
        load_ok = load && (period >= PeriodMin);
        state_d = state_q;
        cnt_d   = cnt_q;
        reload  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (en) begin
                    state_d = StRun;
                    reload  = 1'b1;
                end
            end
            StRun, StStop: begin
                if (wrap) begin
                    cnt_d   = '0;
                    reload  = 1'b1;
                    state_d = en ? StRun : StIdle;
                end else begin
                    cnt_d   = cnt_q + CntOne;
                    state_d = en ? StRun : StStop;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // A run restarts whenever raw changes or after any IDLE cycle.
        same = valid_q && (raw == raw_q);
        if (!same) begin
            run_d = '0;
        end else if (run_q == RunMax) begin
            run_d = run_q;
        end else begin
            run_d = run_q + RunOne;
        end

        settled       = (run_d >= dt_a_q);
        live          = (state_q != StIdle) && (state_d != StIdle);
        ctrl_d        = live && raw && settled;
        ctrl_n_d      = live && !raw && settled;
        cycle_start_d = (state_d == StRun) && (cnt_d == '0);
        load_err_d    = load && !load_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            period_s_q    <= PeriodRst;
            duty_s_q      <= '0;
            dt_s_q        <= '0;
            period_a_q    <= PeriodRst;
            duty_a_q      <= '0;
            dt_a_q        <= '0;
            run_q         <= '0;
            raw_q         <= 1'b0;
            valid_q       <= 1'b0;
            ctrl_q        <= 1'b0;
            ctrl_n_q      <= 1'b0;
            cycle_start_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            raw_q         <= raw;
            valid_q       <= (state_q != StIdle);
            ctrl_q        <= ctrl_d;
            ctrl_n_q      <= ctrl_n_d;
            cycle_start_q <= cycle_start_d;
            load_err_q    <= load_err_d;
            // Active takes the old shadow, so a load on a wrap edge applies one period later.
            if (reload) begin
                period_a_q <= period_s_q;
                duty_a_q   <= duty_s_q;
                dt_a_q     <= dt_s_q;
            end
            if (load_ok) begin
                period_s_q <= period;
                duty_s_q   <= duty;
                dt_s_q     <= deadtime;
            end
        end
    end

    assign ctrl        = ctrl_q;
    assign ctrl_n      = ctrl_n_q;
    assign cycle_start = cycle_start_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: directed literal scenarios plus randomized traffic, all checked every
// cycle against a window-based behavioural model of the PWM rules.
module tb_pwm_gen;

    localparam int CW   = 16;
    localparam int DW   = 8;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] period = '0;
    logic [CW-1:0] duty = '0;
    logic [DW-1:0] deadtime = '0;
    logic          ctrl, ctrl_n, cycle_start, load_err;

    pwm_gen #(.CNT_W(CW), .DT_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .period     (period),
        .duty       (duty),
        .deadtime   (deadtime),
        .ctrl       (ctrl),
        .ctrl_n     (ctrl_n),
        .cycle_start(cycle_start),
        .load_err   (load_err)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural model: running flag, counter, register sets and the raw history of the
    // current uninterrupted run; gate outputs come from the tail of that history.
    bit m_run;
    int m_cnt;
    int sh_p, sh_d, sh_t, ac_p, ac_d, ac_t;
    bit hist[$];
    bit e_ctrl, e_ctrl_n, e_cs, e_lerr;
    bit m_raw, m_nrun, m_copy;
    int m_ncnt, m_s;

    function automatic int streak();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1]) break;
            n++;
        end
        return n;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; m_cnt = 0;
            sh_p = PMAX; sh_d = 0; sh_t = 0;
            ac_p = PMAX; ac_d = 0; ac_t = 0;
            hist.delete();
            e_ctrl = 0; e_ctrl_n = 0; e_cs = 0; e_lerr = 0;
        end else begin
            m_raw = m_run && (m_cnt < ac_d);
            if (m_run) begin
                hist.push_back(m_raw);
                if (hist.size() > 400) void'(hist.pop_front());
            end
            m_copy = 0;
            if (!m_run) begin
                m_nrun = en; m_ncnt = 0; m_copy = en;
            end else if (m_cnt == ac_p - 1) begin
                m_nrun = en; m_ncnt = 0; m_copy = 1;
            end else begin
                m_nrun = 1; m_ncnt = m_cnt + 1;
            end
            m_s      = m_run ? streak() : 0;
            e_ctrl   = m_run && m_nrun && m_raw && (m_s > ac_t);
            e_ctrl_n = m_run && m_nrun && !m_raw && (m_s > ac_t);
            e_cs     = m_nrun && (m_ncnt == 0);
            e_lerr   = load && (int'(period) < 2);
            if (m_copy) begin
                ac_p = sh_p; ac_d = sh_d; ac_t = sh_t;
            end
            if (load && int'(period) >= 2) begin
                sh_p = int'(period); sh_d = int'(duty); sh_t = int'(deadtime);
            end
            if (!m_nrun) hist.delete();
            m_run = m_nrun;
            m_cnt = m_ncnt;
        end
    end

    initial forever begin
        @(negedge clk);
        if ($time > 1) begin
            check("ctrl", ctrl, e_ctrl);
            check("ctrl_n", ctrl_n, e_ctrl_n);
            check("cycle_start", cycle_start, e_cs);
            check("load_err", load_err, e_lerr);
            check("overlap", ctrl & ctrl_n, 0);
        end
    end

    task automatic do_load(input int p, input int d, input int t);
        load = 1'b1;
        period = CW'(p);
        duty = CW'(d);
        deadtime = DW'(t);
        tick();
        load = 1'b0;
    endtask

    task automatic window(input string name, input int exp_hi, input int exp_lo);
        int hi = 0;
        int lo = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(ctrl);
            lo += int'(ctrl_n);
        end
        check({name, "_ctrl_cycles"}, hi, exp_hi);
        check({name, "_ctrl_n_cycles"}, lo, exp_lo);
    endtask

    task automatic wait_cs(input string name);
        int i = 0;
        while (cycle_start !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check(name, cycle_start, 1);
    endtask

    logic [0:20] pat_c = 21'b0_11111_00000_11111_00000;
    logic [0:20] pat_n = 21'b0_00000_11111_00000_11111;
    logic [0:20] pat_s = 21'b1_000000000_1_000000000_1;
    bit need_load;

    initial begin
        #1 rst = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b0;
        tick();
        check("rst_ctrl", ctrl, 0);
        check("rst_ctrl_n", ctrl_n, 0);
        check("rst_cycle_start", cycle_start, 0);
        check("rst_load_err", load_err, 0);

        // period 10, duty 5, no dead-time
        do_load(10, 5, 0);
        en = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            check("pat_ctrl", ctrl, pat_c[k]);
            check("pat_ctrl_n", ctrl_n, pat_n[k]);
            check("pat_cycle_start", cycle_start, pat_s[k]);
        end

        // mid-period load with dead-time; a 2-cycle low pulse is suppressed entirely
        tick(); tick();
        do_load(10, 8, 2);
        repeat (25) tick();
        window("d8dt2", 6, 0);
        do_load(10, 5, 2);
        repeat (25) tick();
        window("d5dt2", 3, 3);

        // rejected load
        load = 1'b1; period = 16'd1; duty = 16'd3; deadtime = 8'd0;
        tick();
        load = 1'b0;
        check("load_err_pulse", load_err, 1);
        tick();
        check("load_err_clear", load_err, 0);
        window("after_err", 3, 3);

        do_load(10, 0, 0);
        repeat (25) tick();
        window("duty0", 0, 10);
        do_load(10, 12, 0);
        repeat (25) tick();
        window("duty12", 10, 0);

        // load on the wrap edge applies one period later
        do_load(10, 5, 0);
        repeat (25) tick();
        wait_cs("wrap_sync");
        repeat (9) tick();
        do_load(10, 8, 0);
        window("wrap_old", 5, 5);
        window("wrap_new", 8, 2);

        // en dropped at cnt 3: period completes, then idle
        do_load(10, 5, 0);
        repeat (25) tick();
        wait_cs("stop_sync");
        repeat (3) tick();
        en = 1'b0;
        repeat (6) tick();
        check("stop_last_ctrl_n", ctrl_n, 1);
        tick();
        check("stop_idle_ctrl", ctrl, 0);
        check("stop_idle_ctrl_n", ctrl_n, 0);
        repeat (5) tick();
        check("stop_idle_cs", cycle_start, 0);

        // asynchronous reset at cnt 4
        en = 1'b1;
        wait_cs("arst_sync");
        repeat (4) tick();
        check("arst_pre_ctrl", ctrl, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", ctrl, 0);
        check("arst_ctrl_n", ctrl_n, 0);
        en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        check("arst_idle_ctrl", ctrl, 0);
        check("arst_idle_cs", cycle_start, 0);

        // randomized traffic
        need_load = 1;
        for (int c = 0; c < 4000; c++) begin
            load = 1'b0;
            if (need_load) begin
                en = 1'b0;
                load = 1'b1;
                period = CW'($urandom_range(20, 2));
                duty = CW'($urandom_range(24, 0));
                deadtime = DW'($urandom_range(7, 0));
                need_load = 0;
            end else begin
                if ($urandom_range(19, 0) == 0) en = ~en;
                if ($urandom_range(7, 0) == 0) begin
                    load = 1'b1;
                    period = CW'($urandom_range(20, 0));
                    duty = CW'($urandom_range(24, 0));
                    deadtime = DW'($urandom_range(7, 0));
                end
            end
            if ($urandom_range(599, 0) == 0) begin
                load = 1'b0;
                en = 1'b0;
                #2 rst = 1'b1;
                tick();
                tick();
                #2 rst = 1'b0;
                need_load = 1;
            end else begin
                tick();
            end
        end
        load = 1'b0;
        en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
